// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the Lapido processor (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional: define TRAP_ILEGAL_EN so an undefined opcode halts the core instead of acting as a NOP.
module unidade_controle #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_data,
    output logic [7:0]          ula_opcode,
    input  logic [3:0]          ula_flags,
    output logic [4:0]          reg_ra_addr,
    output logic [4:0]          reg_rb_addr,
    output logic [4:0]          reg_wr_addr,
    output logic                reg_wr_en,
    output logic [1:0]          reg_wr_sel,
    output logic [31:0]         imm_out,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic [3:0]          flags,
    output logic                halted,
    output logic                ilegal
);
    localparam logic [7:0] OP_LOADLIT = 8'h40;
    localparam logic [7:0] OP_LOAD    = 8'h50;
    localparam logic [7:0] OP_STORE   = 8'h51;
    localparam logic [7:0] OP_J       = 8'h80;
    localparam logic [7:0] OP_JT      = 8'h84;
    localparam logic [7:0] OP_JF      = 8'h88;
    localparam logic [7:0] OP_HALT    = 8'hFF;
    localparam logic [7:0] OP_PASSA   = 8'h35;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] pc, pc_nx;
    logic [31:0]         ir, ir_nx;
    logic [3:0]          flags_nx;

    logic [7:0] op;
    logic       is_ula, is_ll, is_ld, is_st, is_jmp, is_halt, is_ill;
    logic       cond_flag, jmp_taken;

    assign op      = ir[31:24];
    assign is_ula  = (op[7:5] == 3'b001);
    assign is_ll   = (op == OP_LOADLIT);
    assign is_ld   = (op == OP_LOAD);
    assign is_st   = (op == OP_STORE);
    assign is_jmp  = (op == OP_J) || (op == OP_JT) || (op == OP_JF);
    assign is_halt = (op == OP_HALT);
    assign is_ill  = !(is_ula || is_ll || is_ld || is_st || is_jmp || is_halt);

    // cond 0..3 names neg..ovf, which are stored MSB-first, so the bit index is 3-cond
    assign cond_flag = flags[~ir[23:22]];
    assign jmp_taken = (op == OP_J) || ((op == OP_JT) && cond_flag) || ((op == OP_JF) && !cond_flag);

    assign imem_addr   = pc;
    assign reg_ra_addr = ir[18:14];
    assign reg_rb_addr = ir[13:9];
    assign reg_wr_addr = ir[23:19];
    assign imm_out     = {{16{ir[15]}}, ir[15:0]};
    assign reg_wr_sel  = is_ll ? 2'd1 : (is_ld ? 2'd2 : 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            flags <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
            flags <= flags_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        ir_nx      = ir;
        flags_nx   = flags;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_wr_en  = 1'b0;
        ilegal     = 1'b0;
        halted     = 1'b0;
        ula_opcode = OP_PASSA;
        case (state)
            S_FETCH: begin
                // state is already FETCH while reset is held; keep the request quiet until release
                imem_req = !reset;
                if (imem_ack) begin
                    ir_nx    = imem_data;
                    pc_nx    = pc + PC_WIDTH'(1);
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_nx = S_HALT;
                end else if (is_ill) begin
                    ilegal = 1'b1;
`ifdef TRAP_ILEGAL_EN
                    state_nx = S_HALT;
`else
                    state_nx = S_FETCH;
`endif
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_ula) begin
                    ula_opcode = op;
                    state_nx   = S_WB;
                end else if (is_ll) begin
                    state_nx = S_WB;
                end else if (is_ld || is_st) begin
                    state_nx = S_MEM;
                end else begin
                    if (is_jmp && jmp_taken) pc_nx = PC_WIDTH'(ir[15:0]);
                    state_nx = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ack) state_nx = is_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_wr_en = 1'b1;
                if (is_ula) begin
                    ula_opcode = op;
                    flags_nx   = ula_flags;
                end
                state_nx = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_nx = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed plan items then random instructions checked
// against an instruction-level model (expected latency, writes, memory cycles, PC, flags).
module tb_unidade_controle;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [7:0]  ula_opcode;
    logic [3:0]  ula_flags = '0;
    logic [4:0]  reg_ra_addr, reg_rb_addr, reg_wr_addr;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_sel;
    logic [31:0] imm_out;
    logic        dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic [3:0]  flags;
    logic        halted, ilegal;

    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef TRAP_ILEGAL_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    unidade_controle #(.PC_WIDTH(16), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .ula_opcode(ula_opcode), .ula_flags(ula_flags),
        .reg_ra_addr(reg_ra_addr), .reg_rb_addr(reg_rb_addr), .reg_wr_addr(reg_wr_addr),
        .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .imm_out(imm_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .flags(flags), .halted(halted), .ilegal(ilegal)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // architectural state of the reference model
    logic [15:0] m_pc;
    logic [3:0]  m_flags;
    bit          m_halted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [7:0] op);
        return (op >= 8'h20 && op <= 8'h3F) || op == 8'h40 || op == 8'h50 || op == 8'h51 ||
               op == 8'h80 || op == 8'h84 || op == 8'h88 || op == 8'hFF;
    endfunction

    task automatic reset_checks();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'(RST_PC));
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ilegal", 32'(ilegal), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_ula_opcode", 32'(ula_opcode), 32'h35);
        check("rst_imm", imm_out, 32'd0);
        check("rst_addrs", 32'({reg_ra_addr, reg_rb_addr, reg_wr_addr}), 32'd0);
    endtask

    task automatic do_reset(input bit ack_high);
        @(negedge clk);
        reset = 1'b1; imem_ack = ack_high; dmem_ack = ack_high; imem_data = $urandom;
        #1 reset_checks();
        @(negedge clk);
        reset_checks();
        reset = 1'b0;
        m_pc = RST_PC; m_flags = 4'd0; m_halted = 1'b0;
        #1;
    endtask

    task automatic halt_hold();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("halt_sticky", 32'(halted), 32'd1);
            check("halt_no_ireq", 32'(imem_req), 32'd0);
            check("halt_no_dreq", 32'(dmem_req | reg_wr_en), 32'd0);
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    // Runs one instruction from its fetch to the next fetch (or halt); rst_at>0 asserts
    // reset asynchronously during that memory-wait cycle.
    task automatic exec(input logic [31:0] instr, input int dly, input logic [3:0] uf, input int rst_at);
        logic [7:0]  op;
        logic [1:0]  cond;
        bit          ula, ll, ld, st, jmp, hlt, ill, taken, exp_halt, wr, aborted;
        int          lat, k, wr_n, wr_k, il_n, np_n, dm_n, we_n;
        logic [1:0]  wr_sel_o;
        logic [4:0]  wr_addr_o;
        logic [7:0]  np_val;
        logic [15:0] exp_pc;
        logic [3:0]  exp_flags;
        op = instr[31:24]; cond = instr[23:22];
        ula = (op >= 8'h20 && op <= 8'h3F);
        ll = (op == 8'h40); ld = (op == 8'h50); st = (op == 8'h51); hlt = (op == 8'hFF);
        jmp = (op == 8'h80) || (op == 8'h84) || (op == 8'h88);
        ill = !is_legal(op);
        // flags are {neg,zero,carry,ovf}; cond 0 names neg
        taken = (op == 8'h80) || (op == 8'h84 && m_flags[3 - int'(cond)]) ||
                (op == 8'h88 && !m_flags[3 - int'(cond)]);
        exp_halt = hlt || (ill && TRAP);
        wr = ula || ll || ld;
        lat = (ula || ll) ? 4 : ld ? 4 + dly : st ? 3 + dly : jmp ? 3 : 2;
        exp_pc = taken ? instr[15:0] : m_pc + 16'd1;
        exp_flags = ula ? uf : m_flags;
        wr_n = 0; wr_k = 0; il_n = 0; np_n = 0; dm_n = 0; we_n = 0;
        wr_sel_o = '0; wr_addr_o = '0; np_val = '0; aborted = 1'b0;

        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        imem_ack = 1'b1; imem_data = instr; ula_flags = uf;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (k == 1) begin
                check("dec_ra", 32'(reg_ra_addr), 32'(instr[18:14]));
                check("dec_rb", 32'(reg_rb_addr), 32'(instr[13:9]));
                check("dec_imm", imm_out, {{16{instr[15]}}, instr[15:0]});
            end
            if (k == 2 && ula) check("ula_op_exec", 32'(ula_opcode), 32'(op));
            if (reg_wr_en) begin wr_n++; wr_k = k; wr_sel_o = reg_wr_sel; wr_addr_o = reg_wr_addr; end
            if (ilegal) il_n++;
            if (ula_opcode !== 8'h35) begin np_n++; np_val = ula_opcode; end
            if (dmem_req) begin
                dm_n++;
                if (dmem_we) we_n++;
                if (rst_at != 0 && dm_n == rst_at) begin
                    dmem_ack = 1'b0;
                    #1 reset = 1'b1;
                    #1;
                    check("midwait_dmem_req", 32'(dmem_req), 32'd0);
                    check("midwait_pc", 32'(imem_addr), 32'(RST_PC));
                    aborted = 1'b1;
                    break;
                end
                dmem_ack = (dm_n == dly);
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (imem_req || halted) break;
            imem_ack = 1'($urandom_range(0, 1)); imem_data = $urandom;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        if (aborted) return;

        check("latency", 32'(k), 32'(lat));
        check("halted", 32'(halted), 32'(exp_halt));
        if (!exp_halt) check("next_pc", 32'(imem_addr), 32'(exp_pc));
        check("flags", 32'(flags), 32'(exp_flags));
        check("wr_count", 32'(wr_n), wr ? 32'd1 : 32'd0);
        if (wr) begin
            check("wr_cycle", 32'(wr_k), 32'(lat - 1));
            check("wr_sel", 32'(wr_sel_o), ll ? 32'd1 : ld ? 32'd2 : 32'd0);
            check("wr_addr", 32'(wr_addr_o), 32'(instr[23:19]));
        end
        check("dmem_cycles", 32'(dm_n), (ld || st) ? 32'(dly) : 32'd0);
        check("dmem_we_cycles", 32'(we_n), st ? 32'(dly) : 32'd0);
        check("ilegal_pulses", 32'(il_n), ill ? 32'd1 : 32'd0);
        check("ula_op_cycles", 32'(np_n), (ula && op != 8'h35) ? 32'd2 : 32'd0);
        if (np_n != 0) check("ula_op_value", 32'(np_val), 32'(op));
        m_pc = exp_pc; m_flags = exp_flags; m_halted = exp_halt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [31:0] instr;
        m_pc = RST_PC; m_flags = 4'd0; m_halted = 1'b0;

        do_reset(1'b1);                                  // imem_ack held high through reset
        exec(32'h2008_9000, 1, 4'b0100, 0);              // add rc=1 ra=2 rb=8
        exec(32'h4010_FFFE, 1, 4'b1011, 0);              // LOADLIT rc=2, flags untouched
        exec(32'h8440_0040, 1, 4'($urandom), 0);         // JT zero -> 0x0040
        exec(32'h8840_0040, 1, 4'($urandom), 0);         // JF zero -> falls through
        exec(32'h5018_8000, 3, 4'($urandom), 0);         // LOAD, ack after 3 request cycles
        exec(32'h5100_C400, 2, 4'($urandom), 0);         // STORE
        exec(32'h5020_4000, 8, 4'($urandom), 2);         // LOAD interrupted by reset
        do_reset(1'b1);
        exec(32'h7A00_0000, 1, 4'($urandom), 0);         // undefined opcode
        if (m_halted) begin halt_hold(); do_reset(1'b0); end
        exec(32'h8000_FFFF, 1, 4'($urandom), 0);         // jump to last word
        exec(32'h2A08_9000, 1, 4'b1001, 0);              // fetched at 0xFFFF, PC wraps to 0
        exec(32'hFF00_0000, 1, 4'($urandom), 0);         // HALT
        halt_hold();
        do_reset(1'b0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: op = 8'h20 + 8'($urandom_range(0, 31));
                1: op = 8'h40;
                2: op = 8'h50;
                3: op = 8'h51;
                4: op = 8'h80;
                5: op = 8'h84;
                6: op = 8'h88;
                default: begin
                    do op = 8'($urandom); while (is_legal(op));
                end
            endcase
            instr = {op, 24'($urandom)};
            exec(instr, int'($urandom_range(1, 4)), 4'($urandom), 0);
            if (m_halted) begin halt_hold(); do_reset(1'($urandom_range(0, 1))); end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multi-cycle control unit for the Lapido processor.
- Fetches 32-bit instruction words and decodes them.
- Drives the ULA 8-bit opcode and the register-file/memory control strobes, and consumes the ULA result flags.
- Evaluates conditional jumps against the latched flag register. It is the issuing side of the ULA opcode interface; the ULA is the executing side.

Parameters:
- PC_WIDTH, 16, width of the word-addressed program counter.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_addr  out  PC_WIDTH  instruction address (= PC)
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  imem_data valid this cycle
- imem_data  in  32  instruction word
- ula_opcode  out  8  opcode presented to the ULA
- ula_flags  in  4  ULA flags {neg,zero,carry,ovf}, combinational from current opcode/operands
- reg_ra_addr  out  5  operand A register address
- reg_rb_addr  out  5  operand B register address
- reg_wr_addr  out  5  destination register address
- reg_wr_en  out  1  register write strobe, one cycle
- reg_wr_sel  out  2  write source select: 0 = ULA, 1 = imm_out, 2 = data memory
- imm_out  out  32  sign-extended immediate
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (valid with dmem_req)
- dmem_ack  in  1  data memory completion
- flags  out  4  latched flag register {neg,zero,carry,ovf}
- halted  out  1  core stopped
- ilegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Instruction fields:
  - op = [31:24]
  - rc = [23:19]
  - ra = [18:14]
  - rb = [13:9]
  - cond = [23:22]
  - imm16 = [15:0]
- Opcode classes:
  - 0x20-0x3F: ULA op; passed unchanged to ula_opcode; writes rc.
  - 0x40: LOADLIT; rc <= sign-extended imm16.
  - 0x50: LOAD; rc <= mem[ra].
  - 0x51: STORE; mem[ra] <= rb.
  - 0x80: J; unconditional jump.
  - 0x84: JT; jump if flags[cond] = 1.
  - 0x88: JF; jump if flags[cond] = 0.
  - cond mapping: 0 = neg, 1 = zero, 2 = carry, 3 = ovf.
  - 0xFF: HALT.
  - Anything else: illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req = 1 until imem_ack.
  - On ack: IR <= imem_data; PC <= PC + 1, wrapping modulo 2^PC_WIDTH; go to DECODE.
- DECODE:
  - Drive ra/rb/rc addresses and imm_out.
  - HALT opcode -> HALT state.
  - Jumps -> EXEC.
  - All others -> EXEC.
- EXEC:
  - ULA op: ula_opcode = op; go to WB.
  - LOADLIT: go to WB.
  - LOAD/STORE: go to MEM.
  - Jump: if taken, PC <= imm16[PC_WIDTH-1:0] (absolute); then FETCH.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - Hold until dmem_ack.
  - On ack: LOAD -> WB; STORE -> FETCH.
- WB:
  - reg_wr_en = 1 for exactly one cycle with reg_wr_sel per class.
  - ULA ops only: flags <= ula_flags.
  - Then FETCH.
- ula_opcode is held stable from EXEC through WB. Outside ULA ops it is 0x35 (passa).
- Latency with zero-wait memories:
  - ULA op / LOADLIT: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Jump: 3 cycles.
- Jumps never modify flags. The flag register changes only in WB of a ULA op.
- Illegal opcode: ilegal pulses for one cycle in DECODE; the instruction is treated as a NOP (back to FETCH).
- HALT: halted = 1; sticky; no requests issued; only reset exits.
- Reset (asynchronous, any state, including mid-handshake):
  - PC = RESET_PC, state = FETCH, IR = 0, flags = 0.
  - All strobes = 0, halted = 0, ilegal = 0, imm_out = 0, addresses = 0, ula_opcode = 0x35.
  - An outstanding ack arriving after reset deassertion without a request is ignored.
- An ack asserted in a state that does not expect it is ignored.

Optional Feature:
- Macro: TRAP_ILEGAL_EN.
- Defined: an illegal opcode pulses ilegal, then enters HALT (halted = 1, sticky).
- Undefined: an illegal opcode pulses ilegal and continues as a NOP.

Test Plan:
- Reset with imem_ack held high -> imem_addr = 0, all strobes 0, flags = 0; first fetch occurs after reset release.
- Fetch 0x20_08_90_00 (add rc=1, ra=2, rb=8), ula_flags = 4'b0100, zero-wait memory -> ula_opcode = 0x20 in EXEC; reg_wr_en pulse with reg_wr_addr = 1 and sel = 0 in cycle 4; flags = 4'b0100.
- LOADLIT 0x40_10_FF_FE -> imm_out = 0xFFFFFFFE, reg_wr_addr = 2, sel = 1, flags unchanged.
- With flags.zero = 1: JT cond=1 to 0x0040 -> next imem_addr = 0x0040. JF cond=1 to 0x0040 -> next imem_addr = PC + 1.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req held 3 cycles then dropped; reg_wr_en pulse one cycle later with sel = 2. Reset asserted mid-wait -> dmem_req drops immediately and PC = RESET_PC.
- Opcode 0x7A -> ilegal pulse for one cycle. Without TRAP_ILEGAL_EN: next fetch at PC + 1. With it: halted = 1 and no further imem_req. PC at 0xFFFF fetching -> next PC = 0x0000.
